// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction requests into 32-bit words and writes them
// sequentially into an instruction memory, one word per two cycles.
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   CAP       = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic [31:0]       enc_word;
  logic              legal;

  always_comb begin
    legal    = 1'b1;
    enc_word = '0;
    case (kind)
      3'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, funct};
      3'd1:    enc_word = {6'b100011, rs, rt, imm};
      3'd2:    enc_word = {6'b101011, rs, rt, imm};
      3'd3:    enc_word = {6'b000100, rs, rt, imm};
      3'd4:    enc_word = {6'b001000, rs, rt, imm};
      3'd5:    enc_word = {6'b000010, target};
      default: legal    = 1'b0;
    endcase
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign imem_we   = (state == WRITE);
  assign imem_addr = ptr;
  assign imem_wd   = word;

  // Flush outranks everything; the write strobe of a WRITE cycle still shows
  // because it is decoded from the state that cycle, only the increment is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= BASE_ADDR;
      count <= '0;
      err   <= 1'b0;
      word  <= '0;
    end else if (flush) begin
      state <= IDLE;
      ptr   <= BASE_ADDR;
      count <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (legal) begin
              word  <= enc_word;
              state <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          ptr   <= ptr + 1'b1;
          count <= count + 1'b1;
          state <= (count + 1'b1 == CAP) ? FULL : IDLE;
        end
        default: state <= FULL;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a behavioural model tracks a default
// instance under directed and random stimulus; a small instance covers wrap/full.
module tb_instr_encoder;

  localparam int CAP_A = 64;

  logic clk;
  logic reset;

  logic        a_flush, a_valid, a_ready;
  logic [2:0]  a_kind;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [5:0]  a_funct;
  logic [15:0] a_imm;
  logic [25:0] a_target;
  logic        a_we;
  logic [5:0]  a_addr;
  logic [31:0] a_wd;
  logic [6:0]  a_count;
  logic        a_err;

  logic        b_flush, b_valid, b_ready;
  logic [2:0]  b_kind;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [5:0]  b_funct;
  logic [15:0] b_imm;
  logic [25:0] b_target;
  logic        b_we;
  logic [1:0]  b_addr;
  logic [31:0] b_wd;
  logic [2:0]  b_count;
  logic        b_err;

  int tests;
  int fails;
  logic chk_en;

  int          m_ptr;
  int          m_count;
  logic        m_err;
  logic        m_we;
  logic [31:0] m_wd;

  instr_encoder #(.ADDR_W(6), .BASE(0)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_valid), .in_ready(a_ready),
    .kind(a_kind), .rs(a_rs), .rt(a_rt), .rd(a_rd), .funct(a_funct), .imm(a_imm),
    .target(a_target), .imem_we(a_we), .imem_addr(a_addr), .imem_wd(a_wd),
    .count(a_count), .err(a_err)
  );

  instr_encoder #(.ADDR_W(2), .BASE(2)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_valid), .in_ready(b_ready),
    .kind(b_kind), .rs(b_rs), .rt(b_rt), .rd(b_rd), .funct(b_funct), .imm(b_imm),
    .target(b_target), .imem_we(b_we), .imem_addr(b_addr), .imem_wd(b_wd),
    .count(b_count), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] modelEncode(int k, int s, int t, int d, int f, int im, int tg);
    longint op;
    longint w;
    op = 0;
    case (k)
      0: return 32'((longint'(s) << 21) + (longint'(t) << 16) + (longint'(d) << 11) + f);
      1: op = 35;
      2: op = 43;
      3: op = 4;
      4: op = 8;
      5: return 32'((longint'(2) << 26) + tg);
      default: return 32'd0;
    endcase
    w = op * 64'd67108864 + longint'(s) * 2097152 + longint'(t) * 65536 + im;
    return 32'(w);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(logic v, logic [2:0] k, logic [4:0] s, logic [4:0] t,
                               logic [4:0] d, logic [5:0] f, logic [15:0] im, logic [25:0] tg);
    a_valid  = v;
    a_kind   = k;
    a_rs     = s;
    a_rt     = t;
    a_rd     = d;
    a_funct  = f;
    a_imm    = im;
    a_target = tg;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Reference model of instance A: what its outputs must show after each edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr   <= 0;
      m_count <= 0;
      m_err   <= 1'b0;
      m_we    <= 1'b0;
      m_wd    <= 32'd0;
    end else if (a_flush) begin
      m_ptr   <= 0;
      m_count <= 0;
      m_err   <= 1'b0;
      m_we    <= 1'b0;
    end else if (m_we) begin
      m_ptr   <= (m_ptr + 1) % CAP_A;
      m_count <= m_count + 1;
      m_we    <= 1'b0;
    end else if (a_valid && m_count < CAP_A) begin
      if (int'(a_kind) < 6) begin
        m_we <= 1'b1;
        m_wd <= modelEncode(int'(a_kind), int'(a_rs), int'(a_rt), int'(a_rd),
                            int'(a_funct), int'(a_imm), int'(a_target));
      end else begin
        m_err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      checkOutput("cmp_we",    32'(a_we),    32'(m_we));
      checkOutput("cmp_addr",  32'(a_addr),  32'(m_ptr));
      checkOutput("cmp_wd",    a_wd,         m_wd);
      checkOutput("cmp_count", 32'(a_count), 32'(m_count));
      checkOutput("cmp_err",   32'(a_err),   32'(m_err));
      checkOutput("cmp_ready", 32'(a_ready),
                  32'(!m_we && m_count < CAP_A && !a_flush));
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    chk_en  = 1'b0;
    reset   = 1'b0;
    a_flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    b_flush = 1'b0; b_valid = 1'b0; b_kind = 3'd0; b_rs = 5'd0; b_rt = 5'd0;
    b_rd = 5'd0; b_funct = 6'd0; b_imm = 16'd0; b_target = 26'd0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_we_low", 32'(a_we), 32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;
    step();
    checkOutput("rst_ready", 32'(a_ready), 32'd1);
    checkOutput("rst_count", 32'(a_count), 32'd0);
    checkOutput("rst_addr",  32'(a_addr),  32'd0);
    checkOutput("rst_wd",    a_wd,         32'd0);
    checkOutput("rst_err",   32'(a_err),   32'd0);
    checkOutput("rst_b_addr", 32'(b_addr), 32'd2);

    // RTYPE add
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hffff, 26'd0);
    step();
    a_valid = 1'b0;
    checkOutput("rtype_we",   32'(a_we),   32'd1);
    checkOutput("rtype_addr", 32'(a_addr), 32'd0);
    checkOutput("rtype_wd",   a_wd,        32'h00221820);
    step();
    checkOutput("rtype_count", 32'(a_count), 32'd1);
    checkOutput("rtype_we_off", 32'(a_we), 32'd0);

    // Back-to-back LW with valid held
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    applyStimulus(1'b1, 3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0);
    #1;
    checkOutput("lw_ready0", 32'(a_ready), 32'd1);
    step();
    checkOutput("lw_we0",   32'(a_we),    32'd1);
    checkOutput("lw_addr0", 32'(a_addr),  32'd0);
    checkOutput("lw_wd0",   a_wd,         32'h8C080004);
    checkOutput("lw_busy",  32'(a_ready), 32'd0);
    step();
    checkOutput("lw_gap_we", 32'(a_we),    32'd0);
    checkOutput("lw_ready1", 32'(a_ready), 32'd1);
    step();
    checkOutput("lw_we1",   32'(a_we),   32'd1);
    checkOutput("lw_addr1", 32'(a_addr), 32'd1);
    checkOutput("lw_wd1",   a_wd,        32'h8C080004);
    a_valid = 1'b0;
    step();
    checkOutput("lw_count", 32'(a_count), 32'd2);

    // J followed by an illegal kind
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    applyStimulus(1'b1, 3'd5, 5'd31, 5'd31, 5'd0, 6'd0, 16'hbeef, 26'h0000010);
    step();
    checkOutput("j_we",   32'(a_we),   32'd1);
    checkOutput("j_addr", 32'(a_addr), 32'd0);
    checkOutput("j_wd",   a_wd,        32'h08000010);
    a_kind = 3'd6;
    step();
    checkOutput("j_count", 32'(a_count), 32'd1);
    step();
    a_valid = 1'b0;
    checkOutput("ill_err",   32'(a_err),   32'd1);
    checkOutput("ill_we",    32'(a_we),    32'd0);
    checkOutput("ill_count", 32'(a_count), 32'd1);
    step();
    checkOutput("ill_nowrite", 32'(a_we), 32'd0);
    checkOutput("ill_wd_hold", a_wd,       32'h08000010);

    // Reset in the middle of a SW write
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    applyStimulus(1'b1, 3'd2, 5'd29, 5'd31, 5'd0, 6'd0, 16'd0, 26'd0);
    step();
    a_valid = 1'b0;
    checkOutput("sw_we",  32'(a_we), 32'd1);
    checkOutput("sw_wd",  a_wd,      32'hAFBF0000);
    #1 reset = 1'b0;
    #1;
    checkOutput("arst_we",    32'(a_we),    32'd0);
    checkOutput("arst_count", 32'(a_count), 32'd0);
    checkOutput("arst_wd",    a_wd,         32'd0);
    #1 reset = 1'b1;
    step();
    checkOutput("arst_ready", 32'(a_ready), 32'd1);
    checkOutput("arst_count2", 32'(a_count), 32'd0);

    // Small instance: wrap from BASE=2, fill, then flush
    b_kind = 3'd4; b_rs = 5'd0; b_rt = 5'd1; b_imm = 16'd5; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("b_we%0d", i),   32'(b_we),   32'd1);
      checkOutput($sformatf("b_addr%0d", i), 32'(b_addr), 32'((2 + i) % 4));
      checkOutput($sformatf("b_wd%0d", i),   b_wd,        32'h20010005);
      step();
      checkOutput($sformatf("b_cnt%0d", i),  32'(b_count), 32'(i + 1));
    end
    checkOutput("b_full_ready", 32'(b_ready), 32'd0);
    checkOutput("b_full_addr",  32'(b_addr),  32'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("b_full_we%0d", i), 32'(b_we),    32'd0);
      checkOutput($sformatf("b_full_c%0d", i),  32'(b_count), 32'd4);
    end
    b_flush = 1'b1;
    step();
    b_flush = 1'b0;
    #1;
    checkOutput("b_fl_count", 32'(b_count), 32'd0);
    checkOutput("b_fl_err",   32'(b_err),   32'd0);
    checkOutput("b_fl_addr",  32'(b_addr),  32'd2);
    checkOutput("b_fl_ready", 32'(b_ready), 32'd1);
    b_flush = 1'b1;
    #1;
    checkOutput("b_fl_block", 32'(b_ready), 32'd0);
    step();
    b_flush = 1'b0;
    b_valid = 1'b0;
    checkOutput("b_fl_noacc", 32'(b_we),    32'd0);
    checkOutput("b_fl_cnt2",  32'(b_count), 32'd0);

    // Random traffic: first fill toward FULL, then with occasional flushes
    for (int i = 0; i < 600; i++) begin
      logic [2:0] k;
      k = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      applyStimulus(($urandom_range(0, 9) < 8), k, 5'($urandom), 5'($urandom), 5'($urandom),
                    6'($urandom), 16'($urandom), 26'($urandom));
      a_flush = (i >= 300) && ($urandom_range(0, 39) == 0);
      step();
    end
    a_valid = 1'b0;
    a_flush = 1'b0;
    step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
